// File: rtl/vx_axi_read_burst_split.sv
// Splits AXI read bursts from the arbitrated master into sub-bursts that
// respect MAX_BURST_LEN and the AXI 4KB boundary rule.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   m_axi_ar*_in               upstream AR channel (this block is the slave)
//   m_axi_r*_in                upstream R channel (this block is the slave)
//   m_axi_ar*                  downstream AR channel, arid = {final, id}
//   m_axi_r*                   downstream R channel
//
// Only the burst that completes a transaction has the extra ARID MSB set.
// The R path uses that bit to decide which RLAST is forwarded upstream, so it
// needs no state. This relies on same-ID in-order read return.
//
//   state | meaning
//   IDLE  | no burst held, upstream AR accepted
//   SPLIT | sub-burst presented downstream, waiting for arready
module vx_axi_read_burst_split #(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_TID_WIDTH  = 8,
   parameter int MAX_BURST_LEN  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      m_axi_arvalid_in,
   output logic                      m_axi_arready_in,
   input  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr_in,
   input  logic [AXI_TID_WIDTH-1:0]  m_axi_arid_in,
   input  logic [7:0]                m_axi_arlen_in,
   input  logic [2:0]                m_axi_arsize_in,
   input  logic [1:0]                m_axi_arburst_in,
   input  logic [1:0]                m_axi_arlock_in,
   input  logic [3:0]                m_axi_arcache_in,
   input  logic [2:0]                m_axi_arprot_in,
   input  logic [3:0]                m_axi_arqos_in,
   input  logic [3:0]                m_axi_arregion_in,
   output logic                      m_axi_rvalid_in,
   input  logic                      m_axi_rready_in,
   output logic [AXI_DATA_WIDTH-1:0] m_axi_rdata_in,
   output logic                      m_axi_rlast_in,
   output logic [AXI_TID_WIDTH-1:0]  m_axi_rid_in,
   output logic [1:0]                m_axi_rresp_in,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [AXI_TID_WIDTH:0]    m_axi_arid,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic [1:0]                m_axi_arlock,
   output logic [3:0]                m_axi_arcache,
   output logic [2:0]                m_axi_arprot,
   output logic [3:0]                m_axi_arqos,
   output logic [3:0]                m_axi_arregion,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic                      m_axi_rlast,
   input  logic [AXI_TID_WIDTH:0]    m_axi_rid,
   input  logic [1:0]                m_axi_rresp
);

   localparam int AW = AXI_ADDR_WIDTH;
   localparam logic [8:0] MAX_LEN = 9'(MAX_BURST_LEN);

   typedef enum logic [0:0] {IDLE, SPLIT} state_t;

   state_t                   state_q;
   logic [AW-1:0]            addr_q;
   logic [8:0]               rem_q;
   logic [AXI_TID_WIDTH-1:0] id_q;
   logic [2:0]               size_q;
   logic [1:0]               burst_q;
   logic [1:0]               lock_q;
   logic [3:0]               cache_q;
   logic [2:0]               prot_q;
   logic [3:0]               qos_q;
   logic [3:0]               region_q;

   logic [AW-1:0] size_mask;
   logic [11:0]   off_aligned;
   logic [12:0]   to4k;
   logic [8:0]    to4k_clamp;
   logic [8:0]    chunk;
   logic          final_sub;
   logic [AW-1:0] addr_d;
   logic [8:0]    rem_d;

   assign size_mask   = (AW'(1) << size_q) - AW'(1);
   assign off_aligned = addr_q[11:0] & ~size_mask[11:0];
   // Beats left before the 4KB page ends; ranges 1..4096, clamped to the
   // largest possible remaining count so the compare stays 9 bits wide.
   assign to4k        = (13'd4096 - {1'b0, off_aligned}) >> size_q;
   assign to4k_clamp  = (to4k > 13'd256) ? 9'd256 : to4k[8:0];

   always_comb begin
      chunk = rem_q;
      // FIXED/WRAP bursts pass through whole
      if (burst_q == 2'b01) begin
         if (MAX_LEN < chunk)    chunk = MAX_LEN;
         if (to4k_clamp < chunk) chunk = to4k_clamp;
      end
   end

   assign final_sub = (chunk == rem_q);
   assign addr_d    = (addr_q & ~size_mask) + (AW'(chunk) << size_q);
   assign rem_d     = rem_q - chunk;

   assign m_axi_arvalid    = (state_q == SPLIT);
   assign m_axi_arready_in = !reset &&
                             ((state_q == IDLE) || (final_sub && m_axi_arready));

   assign m_axi_araddr   = addr_q;
   assign m_axi_arid     = {final_sub, id_q};
   assign m_axi_arlen    = 8'(chunk - 9'd1);
   assign m_axi_arsize   = size_q;
   assign m_axi_arburst  = burst_q;
   assign m_axi_arlock   = lock_q;
   assign m_axi_arcache  = cache_q;
   assign m_axi_arprot   = prot_q;
   assign m_axi_arqos    = qos_q;
   assign m_axi_arregion = region_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         id_q     <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         lock_q   <= '0;
         cache_q  <= '0;
         prot_q   <= '0;
         qos_q    <= '0;
         region_q <= '0;
      end else if (m_axi_arvalid_in && m_axi_arready_in) begin
         // covers both IDLE and the last sub-burst leaving: no bubble
         state_q  <= SPLIT;
         addr_q   <= m_axi_araddr_in;
         rem_q    <= {1'b0, m_axi_arlen_in} + 9'd1;
         id_q     <= m_axi_arid_in;
         size_q   <= m_axi_arsize_in;
         burst_q  <= m_axi_arburst_in;
         lock_q   <= m_axi_arlock_in;
         cache_q  <= m_axi_arcache_in;
         prot_q   <= m_axi_arprot_in;
         qos_q    <= m_axi_arqos_in;
         region_q <= m_axi_arregion_in;
      end else if (state_q == SPLIT && m_axi_arready) begin
         if (final_sub) begin
            state_q <= IDLE;
         end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
         end
      end
   end

   assign m_axi_rvalid_in = m_axi_rvalid;
   assign m_axi_rready    = m_axi_rready_in;
   assign m_axi_rdata_in  = m_axi_rdata;
   assign m_axi_rresp_in  = m_axi_rresp;
   assign m_axi_rid_in    = m_axi_rid[AXI_TID_WIDTH-1:0];
   assign m_axi_rlast_in  = m_axi_rlast & m_axi_rid[AXI_TID_WIDTH];

endmodule
